cpu_bus_requester: RTL

- Synthesizable CPU-side master for the bus-1 (CPU↔Cache) protocol; replaces hand-sequenced bus-1 driving in benches and feeds a core model.
- Takes a single request (command, address, write data) over valid/ready and sequences the two-beat command/address transfer.
- Releases the bus, waits for the cache RESPONSE, collects one or two data beats and returns the result.
- Generalised in address/data widths, with a response timeout. Bus tristating (drive enable) lives in the parent.

---
 rtl/cpu_bus_requester.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_requester.sv
// CPU-side bus-1 master: accepts one request, drives the two-beat command/address
// transfer, releases the bus, then collects the cache RESPONSE (one or two data beats).
module cpu_bus_requester #(
    parameter int ADDR_W   = 19,
    parameter int OFFSET_W = 4,
    parameter int A_BUS_W  = 15,
    parameter int D_BUS_W  = 16,
    parameter int C_BUS_W  = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [C_BUS_W-1:0]     req_cmd,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [2*D_BUS_W-1:0]   req_wdata,
    output logic                   resp_valid,
    output logic [2*D_BUS_W-1:0]   resp_rdata,
    output logic                   resp_timeout,
    output logic                   bus_oe,
    output logic [A_BUS_W-1:0]     A1_out,
    output logic [D_BUS_W-1:0]     D1_out,
    output logic [C_BUS_W-1:0]     C1_out,
    input  logic [C_BUS_W-1:0]     C1_in,
    input  logic [D_BUS_W-1:0]     D1_in
);

    localparam int RD_W  = 2 * D_BUS_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [C_BUS_W-1:0] CMD_NOP      = C_BUS_W'(0);
    localparam logic [C_BUS_W-1:0] CMD_READ8    = C_BUS_W'(1);
    localparam logic [C_BUS_W-1:0] CMD_READ16   = C_BUS_W'(2);
    localparam logic [C_BUS_W-1:0] CMD_READ32   = C_BUS_W'(3);
    localparam logic [C_BUS_W-1:0] CMD_WRITE8   = C_BUS_W'(5);
    localparam logic [C_BUS_W-1:0] CMD_WRITE16  = C_BUS_W'(6);
    localparam logic [C_BUS_W-1:0] CMD_WRITE32  = C_BUS_W'(7);
    localparam logic [C_BUS_W-1:0] CODE_RESP    = C_BUS_W'(7);
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR1,
        ADDR2,
        TURN,
        WAIT,
        RESP2,
        DONE
    } state_t;

    state_t                 state;
    logic [C_BUS_W-1:0]     cmd_reg;
    logic [OFFSET_W-1:0]    offset_reg;
    logic [D_BUS_W-1:0]     wdata_hi_reg;
    logic [D_BUS_W-1:0]     lo_reg;
    logic [CNT_W-1:0]       cnt_reg;

    // Single-beat read formatting; multi-beat READ32 is assembled in RESP2.
    function automatic logic [RD_W-1:0] fmt_single(input logic [C_BUS_W-1:0] c,
                                                   input logic [D_BUS_W-1:0] d);
        logic [RD_W-1:0] r;
        r = '0;
        if (c == CMD_READ8)
            r = RD_W'(d[7:0]);
        else if (c == CMD_READ16)
            r = RD_W'(d);
        return r;
    endfunction

    // Ready is a pure decode of IDLE, forced low while reset is held.
    assign req_ready = (state == IDLE) && !RESET;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            cmd_reg      <= '0;
            offset_reg   <= '0;
            wdata_hi_reg <= '0;
            lo_reg       <= '0;
            cnt_reg      <= '0;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            resp_rdata   <= '0;
            bus_oe       <= 1'b0;
            A1_out       <= '0;
            D1_out       <= '0;
            C1_out       <= '0;
        end else begin
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cmd_reg      <= req_cmd;
                        offset_reg   <= req_addr[OFFSET_W-1:0];
                        wdata_hi_reg <= req_wdata[RD_W-1:D_BUS_W];
                        if (req_cmd == CMD_NOP) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state  <= ADDR1;
                            bus_oe <= 1'b1;
                            C1_out <= req_cmd;
                            A1_out <= A_BUS_W'(req_addr[ADDR_W-1:OFFSET_W]);
                            if (req_cmd == CMD_WRITE8)
                                D1_out <= D_BUS_W'(req_wdata[7:0]);
                            else if (req_cmd == CMD_WRITE16 || req_cmd == CMD_WRITE32)
                                D1_out <= req_wdata[D_BUS_W-1:0];
                            else
                                D1_out <= '0;
                        end
                    end
                end
                ADDR1: begin
                    state  <= ADDR2;
                    A1_out <= A_BUS_W'(offset_reg);
                    D1_out <= (cmd_reg == CMD_WRITE32) ? wdata_hi_reg : '0;
                end
                ADDR2: begin
                    state  <= TURN;
                    bus_oe <= 1'b0;
                    A1_out <= '0;
                    D1_out <= '0;
                    C1_out <= '0;
                end
                TURN: begin
                    state   <= WAIT;
                    cnt_reg <= '0;
                end
                WAIT: begin
                    // A RESPONSE takes priority over an expiring counter.
                    if (C1_in == CODE_RESP) begin
                        lo_reg <= D1_in;
                        if (cmd_reg == CMD_READ32) begin
                            state <= RESP2;
                        end else begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= fmt_single(cmd_reg, D1_in);
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        state        <= DONE;
                        resp_valid   <= 1'b1;
                        resp_timeout <= 1'b1;
                        resp_rdata   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP2: begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    resp_rdata <= {D1_in, lo_reg};
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
